// File: rtl/noc_parameters.sv
// Shared NoC constants: field widths, initiator IDs, the return path to each
// initiator, and the layout of one outstanding-response slot.
package noc_parameters;

  localparam int SRC_W  = 4;
  localparam int TAG_W  = 4;
  localparam int PATH_W = 7;

  localparam logic [SRC_W-1:0] INIT_ID_A = 4'h1;
  localparam logic [SRC_W-1:0] INIT_ID_B = 4'h2;
  localparam logic [SRC_W-1:0] INIT_ID_C = 4'h3;

  // First hop sits in the LSBs, last hop in the MSBs.
  localparam logic [PATH_W-1:0] PATH_TO_A = 7'b0000001;
  localparam logic [PATH_W-1:0] PATH_TO_B = 7'b0000010;
  localparam logic [PATH_W-1:0] PATH_TO_C = 7'b0000100;

  typedef struct packed {
    logic              failed;
    logic [PATH_W-1:0] path;
    logic [SRC_W-1:0]  source;
    logic [TAG_W-1:0]  tag;
  } slot_t;

endpackage

// File: rtl/routing_target_lut.sv
// Return-path lookup for this target NI. Unknown sources yield path 0
// with failed_o raised.
module routing_target_lut
  import noc_parameters::*;
(
  input  logic [SRC_W-1:0]  source_i,
  output logic [PATH_W-1:0] path_o,
  output logic              failed_o
);

  always_comb begin
    path_o   = '0;
    failed_o = 1'b0;
    unique case (source_i)
      INIT_ID_A: path_o = PATH_TO_A;
      INIT_ID_B: path_o = PATH_TO_B;
      INIT_ID_C: path_o = PATH_TO_C;
      default:   failed_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/routing_target_response.sv
// Response-side routing: an in-order FIFO of {failed, path, source, tag}
// captured from request headers and presented with each response header.
module routing_target_response
  import noc_parameters::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       req_hdr_valid,
  output logic                       req_hdr_ready,
  input  logic [SRC_W-1:0]           req_source,
  input  logic [TAG_W-1:0]           req_tag,
  output logic                       resp_hdr_valid,
  input  logic                       resp_hdr_accept,
  output logic [PATH_W-1:0]          resp_path,
  output logic [SRC_W-1:0]           resp_target,
  output logic [TAG_W-1:0]           resp_tag,
  output logic                       failed_decoding,
  output logic [$clog2(DEPTH):0]     outstanding
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  slot_t            slots_q [DEPTH];
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [PATH_W-1:0] lutPath;
  logic              lutFailed;
  logic              push, pop;
  slot_t             newSlot, headSlot;

  routing_target_lut u_lut (
    .source_i (req_source),
    .path_o   (lutPath),
    .failed_o (lutFailed)
  );

  assign req_hdr_ready  = (count_q != CNT_W'(DEPTH));
  assign resp_hdr_valid = (count_q != '0);

  always_comb begin
    push    = req_hdr_valid & req_hdr_ready;
    pop     = resp_hdr_valid & resp_hdr_accept;
    newSlot = '{failed: lutFailed, path: lutPath, source: req_source, tag: req_tag};
    wrPtr_d = push ? wrPtr_q + PTR_W'(1) : wrPtr_q;
    rdPtr_d = pop  ? rdPtr_q + PTR_W'(1) : rdPtr_q;
    count_d = count_q;
    if (push && !pop) count_d = count_q + CNT_W'(1);
    else if (pop && !push) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) slots_q[i] <= '0;
    end else begin
      if (push) slots_q[wrPtr_q] <= newSlot;
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Head fields read as zero whenever nothing is held.
  always_comb begin
    headSlot = '0;
    if (resp_hdr_valid) headSlot = slots_q[rdPtr_q];
  end

  assign resp_path       = headSlot.path;
  assign resp_target     = headSlot.source;
  assign resp_tag        = headSlot.tag;
  assign failed_decoding = headSlot.failed;
  assign outstanding     = count_q;

endmodule

// File: tb/tb_routing_target_response.sv
// Directed and randomized bench for routing_target_response, checked
// against a queue-based model of the outstanding responses.
module tb_routing_target_response;

  localparam int DEPTH = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic       reqValid;
  logic       reqReady;
  logic [3:0] reqSource;
  logic [3:0] reqTag;
  logic       respValid;
  logic       respAccept;
  logic [6:0] respPath;
  logic [3:0] respTarget;
  logic [3:0] respTag;
  logic       failedDecoding;
  logic [2:0] outstanding;

  int compareCount = 0;
  int failCount    = 0;

  typedef struct {
    logic [3:0] source;
    logic [3:0] tag;
  } entry_t;

  entry_t modelQ[$];

  always #5 clock = ~clock;

  routing_target_response #(.DEPTH(DEPTH)) dut (
    .clock           (clock),
    .reset           (reset),
    .req_hdr_valid   (reqValid),
    .req_hdr_ready   (reqReady),
    .req_source      (reqSource),
    .req_tag         (reqTag),
    .resp_hdr_valid  (respValid),
    .resp_hdr_accept (respAccept),
    .resp_path       (respPath),
    .resp_target     (respTarget),
    .resp_tag        (respTag),
    .failed_decoding (failedDecoding),
    .outstanding     (outstanding)
  );

  // Known initiators 1..3 map to a one-hot path, bit (id-1).
  function automatic logic [6:0] routeOf(input logic [3:0] src);
    if (src >= 4'd1 && src <= 4'd3) return 7'(1 << (src - 1));
    return 7'd0;
  endfunction

  task automatic compare(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compareCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    int n = modelQ.size();
    compare({tag, ":valid"}, 32'(respValid), 32'(n != 0));
    compare({tag, ":ready"}, 32'(reqReady), 32'(n != DEPTH));
    compare({tag, ":outstanding"}, 32'(outstanding), 32'(n));
    if (n != 0) begin
      compare({tag, ":path"}, 32'(respPath), 32'(routeOf(modelQ[0].source)));
      compare({tag, ":target"}, 32'(respTarget), 32'(modelQ[0].source));
      compare({tag, ":tag"}, 32'(respTag), 32'(modelQ[0].tag));
      compare({tag, ":failed"}, 32'(failedDecoding), 32'(routeOf(modelQ[0].source) == 7'd0));
    end else begin
      compare({tag, ":emptyHead"}, 32'({respPath, respTarget, respTag, failedDecoding}), 32'd0);
    end
  endtask

  // One clock: drive at the falling edge, update the model, check at the next falling edge.
  task automatic applyStimulus(input string tag, input logic v, input logic [3:0] s,
                               input logic [3:0] t, input logic a);
    bit pushOk, popOk;
    entry_t e;
    reqValid   = v;
    reqSource  = s;
    reqTag     = t;
    respAccept = a;
    pushOk = v && (modelQ.size() < DEPTH);
    popOk  = a && (modelQ.size() > 0);
    @(posedge clock);
    if (popOk) void'(modelQ.pop_front());
    if (pushOk) begin
      e.source = s;
      e.tag    = t;
      modelQ.push_back(e);
    end
    @(negedge clock);
    checkOutput(tag);
  endtask

  task automatic doReset(input string tag);
    reset      = 1'b1;
    reqValid   = 1'b0;
    reqSource  = '0;
    reqTag     = '0;
    respAccept = 1'b0;
    @(posedge clock);
    modelQ.delete();
    @(negedge clock);
    reset = 1'b0;
    checkOutput(tag);
  endtask

  initial begin
    $display("[TB] start");
    @(negedge clock);
    doReset("reset");

    applyStimulus("single_push", 1'b1, 4'h2, 4'h5, 1'b0);
    applyStimulus("single_pop", 1'b0, 4'h0, 4'h0, 1'b1);
    applyStimulus("empty_accept", 1'b0, 4'h0, 4'h0, 1'b1);

    applyStimulus("fill0", 1'b1, 4'h1, 4'h1, 1'b0);
    applyStimulus("fill1", 1'b1, 4'h2, 4'h2, 1'b0);
    applyStimulus("fill2", 1'b1, 4'h3, 4'h3, 1'b0);
    applyStimulus("fill3", 1'b1, 4'h1, 4'h4, 1'b0);
    applyStimulus("push_full", 1'b1, 4'h2, 4'hF, 1'b0);
    applyStimulus("pop_full", 1'b0, 4'h0, 4'h0, 1'b1);
    applyStimulus("drain1", 1'b0, 4'h0, 4'h0, 1'b1);
    applyStimulus("drain2", 1'b0, 4'h0, 4'h0, 1'b1);
    applyStimulus("drain3", 1'b0, 4'h0, 4'h0, 1'b1);

    applyStimulus("hold0", 1'b1, 4'h3, 4'h8, 1'b0);
    applyStimulus("hold1", 1'b1, 4'h1, 4'h9, 1'b0);
    for (int i = 0; i < 8; i++)
      applyStimulus("pushpop", 1'b1, 4'((i % 3) + 1), 4'(i), 1'b1);
    applyStimulus("hold_drain0", 1'b0, 4'h0, 4'h0, 1'b1);
    applyStimulus("hold_drain1", 1'b0, 4'h0, 4'h0, 1'b1);

    applyStimulus("bad_push", 1'b1, 4'h9, 4'h6, 1'b0);
    applyStimulus("bad_then_good", 1'b1, 4'h2, 4'h7, 1'b1);
    applyStimulus("bad_cleared", 1'b0, 4'h0, 4'h0, 1'b1);

    applyStimulus("pre_reset0", 1'b1, 4'h1, 4'hA, 1'b0);
    applyStimulus("pre_reset1", 1'b1, 4'h2, 4'hB, 1'b0);
    applyStimulus("pre_reset2", 1'b1, 4'h3, 4'hC, 1'b0);
    doReset("mid_reset");
    applyStimulus("post_reset_push", 1'b1, 4'h3, 4'hD, 1'b0);

    for (int i = 0; i < 300; i++)
      applyStimulus("random", 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                    4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
